// File: rtl/fsk_period_demod.sv
// FSK period demodulator: counts carrier rising edges per gate window, slices the count with hysteresis
// and qualifies the result with a carrier lock FSM. Optional macro: FSK_DEMOD_GLITCH_FILTER_EN.
module fsk_period_demod #(
  parameter int GATE_CYCLES  = 2000,
  parameter int COUNT_WIDTH  = 12,
  parameter int THRESHOLD    = 200,
  parameter int HYST         = 1,
  parameter int MIN_EDGES    = 180,
  parameter int MAX_EDGES    = 220,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n,
  input  logic                   rf_i,
  output logic                   demod_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   count_valid_o,
  output logic                   carrier_o
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t                 state, state_nx;
  logic [GOOD_W-1:0]      good_cnt, good_nx;
  logic [2:0]             sync;
  logic [GATE_W-1:0]      gate_cnt;
  logic [COUNT_WIDTH-1:0] edge_cnt, cnt_next;
  logic                   decision, dec_nx;
  logic                   edge_flag, win_close, in_range, raw_one, raw_zero, raw;

`ifdef FSK_DEMOD_GLITCH_FILTER_EN
  logic pend_v, pend_v_nx, pend_d, pend_d_nx;
`endif

  assign edge_flag = sync[1] & ~sync[2];
  assign win_close = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
  // Saturating count including an edge flagged on this very cycle; at window close it is the closing count.
  assign cnt_next  = (edge_flag && edge_cnt != COUNT_MAX) ? edge_cnt + COUNT_WIDTH'(1) : edge_cnt;
  assign in_range  = (cnt_next >= COUNT_WIDTH'(MIN_EDGES)) && (cnt_next <= COUNT_WIDTH'(MAX_EDGES));
  assign raw_one   = (cnt_next <= COUNT_WIDTH'(THRESHOLD - HYST));
  assign raw_zero  = (cnt_next >= COUNT_WIDTH'(THRESHOLD + HYST));
  assign raw       = raw_one;

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    dec_nx   = decision;
`ifdef FSK_DEMOD_GLITCH_FILTER_EN
    pend_v_nx = pend_v;
    pend_d_nx = pend_d;
`endif
    if (win_close) begin
      if (in_range) begin
        if (raw_one || raw_zero) begin
`ifdef FSK_DEMOD_GLITCH_FILTER_EN
          // Commit only when the previous sliced window agreed.
          if (pend_v && pend_d == raw) dec_nx = raw;
          pend_v_nx = 1'b1;
          pend_d_nx = raw;
`else
          dec_nx = raw;
`endif
        end
        if (state == SEARCH) begin
          if (good_cnt == GOOD_W'(LOCK_WINDOWS - 1)) begin
            state_nx = LOCKED;
            good_nx  = '0;
          end else begin
            good_nx = good_cnt + GOOD_W'(1);
          end
        end
      end else begin
        state_nx = SEARCH;
        good_nx  = '0;
`ifdef FSK_DEMOD_GLITCH_FILTER_EN
        pend_v_nx = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sync          <= '0;
      gate_cnt      <= '0;
      edge_cnt      <= '0;
      count_o       <= '0;
      count_valid_o <= 1'b0;
      state         <= SEARCH;
      good_cnt      <= '0;
      decision      <= 1'b0;
      carrier_o     <= 1'b0;
      demod_o       <= 1'b0;
`ifdef FSK_DEMOD_GLITCH_FILTER_EN
      pend_v        <= 1'b0;
      pend_d        <= 1'b0;
`endif
    end else begin
      sync          <= {sync[1:0], rf_i};
      count_valid_o <= win_close;
      state         <= state_nx;
      good_cnt      <= good_nx;
      decision      <= dec_nx;
      carrier_o     <= (state_nx == LOCKED);
      demod_o       <= (state_nx == LOCKED) & dec_nx;
`ifdef FSK_DEMOD_GLITCH_FILTER_EN
      pend_v        <= pend_v_nx;
      pend_d        <= pend_d_nx;
`endif
      if (win_close) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        count_o  <= cnt_next;
      end else begin
        gate_cnt <= gate_cnt + GATE_W'(1);
        edge_cnt <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_fsk_period_demod.sv
// Directed bench for fsk_period_demod with a shortened gate: each table row drives an exact number of
// carrier edges into one window and checks the resulting count, carrier and demod outputs.
module tb_fsk_period_demod;

  localparam int G    = 100;
  localparam int CW   = 5;
  localparam int TH   = 20;
  localparam int HY   = 1;
  localparam int MINE = 18;
  localparam int MAXE = 22;
  localparam int LW   = 4;
  localparam int NV   = 23;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rf = 1'b0;
  logic          demod_o, count_valid_o, carrier_o;
  logic [CW-1:0] count_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rel = 0;

  typedef struct {
    int edges;
    int exp_count;
    bit exp_carrier;
    bit exp_demod;
    bit exp_demod_f;
  } vec_t;

  vec_t vecs[NV];

  fsk_period_demod #(
    .GATE_CYCLES(G), .COUNT_WIDTH(CW), .THRESHOLD(TH), .HYST(HY),
    .MIN_EDGES(MINE), .MAX_EDGES(MAXE), .LOCK_WINDOWS(LW)
  ) dut (
    .clk_i(clk), .reset_n(reset_n), .rf_i(rf), .demod_o(demod_o),
    .count_o(count_o), .count_valid_o(count_valid_o), .carrier_o(carrier_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; one rising edge every two cycles.
  task automatic drive_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      rf = 1'b1;
      @(negedge clk);
      rf = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < G + 10 && !seen; i++) begin
      @(negedge clk);
      if (count_valid_o) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: no count_valid_o within %0d cycles", G + 10);
    end
  endtask

  task automatic check_latency();
    int lat;
    lat = cyc - rel;
    checks++;
    if (lat != G && lat != G + 1) begin
      errors++;
      $display("FAIL valid_latency: got %0d cycles expected %0d or %0d", lat, G, G + 1);
    end
  endtask

  task automatic check_pulse_width();
    @(negedge clk);
    check("valid_one_cycle", int'(count_valid_o), 0);
  endtask

  function automatic vec_t mk(input int e, input int c, input bit car, input bit d, input bit df);
    vec_t v;
    v.edges = e; v.exp_count = c; v.exp_carrier = car; v.exp_demod = d; v.exp_demod_f = df;
    return v;
  endfunction

  initial begin
    bit seen;
    bit exp_d;
    // edges, count, carrier, demod (no filter), demod (filter)
    vecs[0]  = mk(22, 22, 0, 0, 0);
    vecs[1]  = mk(21, 21, 0, 0, 0);
    vecs[2]  = mk(22, 22, 0, 0, 0);
    vecs[3]  = mk(21, 21, 1, 0, 0);  // 4th in-range window locks
    vecs[4]  = mk(19, 19, 1, 1, 0);
    vecs[5]  = mk(20, 20, 1, 1, 0);  // hysteresis band holds
    vecs[6]  = mk(18, 18, 1, 1, 1);  // MIN_EDGES boundary
    vecs[7]  = mk(23, 23, 0, 0, 0);  // just above MAX_EDGES drops lock
    vecs[8]  = mk(22, 22, 0, 0, 0);
    vecs[9]  = mk(18, 18, 0, 0, 0);
    vecs[10] = mk(20, 20, 0, 0, 0);
    vecs[11] = mk(19, 19, 1, 1, 1);
    vecs[12] = mk(21, 21, 1, 0, 1);
    vecs[13] = mk(22, 22, 1, 0, 0);
    vecs[14] = mk(0,  0,  0, 0, 0);  // stuck input
    vecs[15] = mk(40, 31, 0, 0, 0);  // counter saturates
    vecs[16] = mk(17, 17, 0, 0, 0);  // just below MIN_EDGES
    vecs[17] = mk(21, 21, 0, 0, 0);
    vecs[18] = mk(22, 22, 0, 0, 0);
    vecs[19] = mk(21, 21, 0, 0, 0);
    vecs[20] = mk(22, 22, 1, 0, 0);
    vecs[21] = mk(19, 19, 1, 1, 0);
    vecs[22] = mk(19, 19, 1, 1, 1);

    repeat (3) @(negedge clk);
    check("rst_count", int'(count_o), 0);
    check("rst_valid", int'(count_valid_o), 0);
    check("rst_carrier", int'(carrier_o), 0);
    check("rst_demod", int'(demod_o), 0);
    reset_n = 1'b1;
    rel = cyc;

    for (int k = 0; k < NV; k++) begin
      drive_pulses(vecs[k].edges);
      wait_valid(seen);
      if (seen) begin
        if (k == 0) check_latency();
`ifdef FSK_DEMOD_GLITCH_FILTER_EN
        exp_d = vecs[k].exp_demod_f;
`else
        exp_d = vecs[k].exp_demod;
`endif
        check($sformatf("win%0d_count", k), int'(count_o), vecs[k].exp_count);
        check($sformatf("win%0d_carrier", k), int'(carrier_o), int'(vecs[k].exp_carrier));
        check($sformatf("win%0d_demod", k), int'(demod_o), int'(exp_d));
        check_pulse_width();
      end
    end

    // Reset mid-window while locked with demod high: outputs clear asynchronously.
    drive_pulses(10);
    #2 reset_n = 1'b0;
    #1;
    check("async_count", int'(count_o), 0);
    check("async_carrier", int'(carrier_o), 0);
    check("async_demod", int'(demod_o), 0);
    check("async_valid", int'(count_valid_o), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;

    // Partial pre-reset edges are discarded; relock needs four fresh windows.
    for (int w = 0; w < LW; w++) begin
      drive_pulses(21);
      wait_valid(seen);
      if (seen) begin
        if (w == 0) check_latency();
        check($sformatf("relock%0d_count", w), int'(count_o), 21);
        check($sformatf("relock%0d_carrier", w), int'(carrier_o), (w == LW - 1) ? 1 : 0);
        check($sformatf("relock%0d_demod", w), int'(demod_o), 0);
        check_pulse_width();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
